// File: rtl/hs_pkg.sv
// Shared types for the bundled-data handshake FIFO.
// State encodings and signalling-mode selectors.
package hs_pkg;

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_LOAD,
        OUT_REQ,
        OUT_RTZ
    } out_state_t;

    localparam int PH4 = 0;
    localparam int PH2 = 1;

endpackage

// File: rtl/hs_sync.sv
// N-deep flop chain bringing an asynchronous level into the clk domain.
// N=0 degenerates to a wire for inputs that are already synchronous.
module hs_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (N == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [N-1:0] sr_q;
            logic [N-1:0] sr_d;

            always_comb begin
                sr_d    = sr_q << 1;
                sr_d[0] = d;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q = sr_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/hs_bundled_fifo.sv
// Clocked FIFO bridging two self-timed bundled-data req/ack channels.
// Input and output sides are independent FSMs sharing a registered count.
module hs_bundled_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 4,
    parameter int SYNC      = 2,
    parameter int TWO_PHASE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ack_in,
    output logic                       req_out,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       ack_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic req_in_s;
    logic ack_out_s;

    hs_sync #(.N(SYNC)) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_in_s)
    );

    hs_sync #(.N(SYNC)) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (ack_out),
        .q   (ack_out_s)
    );

    logic [WIDTH-1:0] mem [DEPTH];

    in_state_t        in_state_q,  in_state_d;
    out_state_t       out_state_q, out_state_d;
    logic [AW-1:0]    wptr_q,      wptr_d;
    logic [AW-1:0]    rptr_q,      rptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             ack_in_q,    ack_in_d;
    logic             req_out_q,   req_out_d;
    logic [WIDTH-1:0] data_out_q,  data_out_d;
    logic             last_req_q,  last_req_d;
    logic             push;
    logic             pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        ack_in_d    = ack_in_q;
        req_out_d   = req_out_q;
        data_out_d  = data_out_q;
        last_req_d  = last_req_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (TWO_PHASE == PH2) begin
            if (req_in_s != last_req_q && !full) begin
                push       = 1'b1;
                ack_in_d   = !ack_in_q;
                last_req_d = req_in_s;
            end
        end else begin
            unique case (in_state_q)
                IN_IDLE: begin
                    if (req_in_s && !full) begin
                        push       = 1'b1;
                        ack_in_d   = 1'b1;
                        in_state_d = IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!req_in_s) begin
                        ack_in_d   = 1'b0;
                        in_state_d = IN_IDLE;
                    end
                end
            endcase
        end

        // data_out is captured on entry to LOAD so it leads req_out by one clk
        unique case (out_state_q)
            OUT_IDLE: begin
                if (!empty) begin
                    data_out_d  = mem[rptr_q];
                    out_state_d = OUT_LOAD;
                end
            end
            OUT_LOAD: begin
                req_out_d   = (TWO_PHASE == PH2) ? !req_out_q : 1'b1;
                out_state_d = OUT_REQ;
            end
            OUT_REQ: begin
                if (TWO_PHASE == PH2) begin
                    if (ack_out_s == req_out_q) begin
                        pop         = 1'b1;
                        out_state_d = OUT_IDLE;
                    end
                end else if (ack_out_s) begin
                    pop         = 1'b1;
                    req_out_d   = 1'b0;
                    out_state_d = OUT_RTZ;
                end
            end
            OUT_RTZ: begin
                if (!ack_out_s) begin
                    out_state_d = OUT_IDLE;
                end
            end
        endcase

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ack_in_q    <= 1'b0;
            req_out_q   <= 1'b0;
            data_out_q  <= '0;
            last_req_q  <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ack_in_q    <= ack_in_d;
            req_out_q   <= req_out_d;
            data_out_q  <= data_out_d;
            last_req_q  <= last_req_d;
        end
    end

    assign ack_in   = ack_in_q;
    assign req_out  = req_out_q;
    assign data_out = data_out_q;
    assign count    = count_q;

endmodule

// File: tb/tb_hs_bundled_fifo.sv
// Scoreboard bench for hs_bundled_fifo: a 4-phase and a 2-phase instance.
// Drivers push expected words; monitors pop and compare on each req_out event.
module tb_hs_bundled_fifo;

    localparam int W = 3;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req_a, ack_in_a, req_out_a, ack_out_a, full_a, empty_a;
    logic [W-1:0] din_a, dout_a;
    logic [2:0]   cnt_a;
    logic         req_b, ack_in_b, req_out_b, ack_out_b, full_b, empty_b;
    logic [W-1:0] din_b, dout_b;
    logic [2:0]   cnt_b;

    hs_bundled_fifo #(.WIDTH(W), .DEPTH(D), .SYNC(2), .TWO_PHASE(0)) u_a (
        .clk(clk), .rst(rst), .req_in(req_a), .data_in(din_a),
        .ack_in(ack_in_a), .req_out(req_out_a), .data_out(dout_a),
        .ack_out(ack_out_a), .count(cnt_a), .full(full_a), .empty(empty_a)
    );

    hs_bundled_fifo #(.WIDTH(W), .DEPTH(D), .SYNC(2), .TWO_PHASE(1)) u_b (
        .clk(clk), .rst(rst), .req_in(req_b), .data_in(din_b),
        .ack_in(ack_in_b), .req_out(req_out_b), .data_out(dout_b),
        .ack_out(ack_out_b), .count(cnt_b), .full(full_b), .empty(empty_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic hold_a = 1'b1;
    logic rnd_a = 1'b0;
    int n_rx_a = 0;
    int n_rx_b = 0;
    int n_reqt_b = 0;
    int n_ackt_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ack_a(input logic v, input string nm);
        for (int i = 0; i < 200 && ack_in_a !== v; i++) @(negedge clk);
        chk(nm, 32'(ack_in_a), 32'(v));
    endtask

    task automatic send_a(input logic [W-1:0] d);
        @(posedge clk);
        #1;
        din_a = d;
        req_a = 1'b1;
        q_a.push_back(d);
        wait_ack_a(1'b1, "ack_in_a_rise");
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_ack_a(1'b0, "ack_in_a_fall");
    endtask

    task automatic drain_a(input string nm);
        for (int i = 0; i < 2000 && (cnt_a != 0 || req_out_a); i++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk({nm, "_count"}, 32'(cnt_a), 0);
        chk({nm, "_queue_left"}, q_a.size(), 0);
    endtask

    task automatic send_b(input logic [W-1:0] d);
        int i;
        @(posedge clk);
        #1;
        din_b = d;
        req_b = ~req_b;
        q_b.push_back(d);
        for (i = 0; i < 200 && ack_in_b !== req_b; i++) @(negedge clk);
        chk("ack_in_b_toggle", 32'(ack_in_b), 32'(req_b));
    endtask

    // Monitor A: a new token is announced by a rising req_out.
    initial begin
        logic prev;
        logic [W-1:0] held;
        logic [W-1:0] e;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (req_out_a && !prev) begin
                if (q_a.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stray_req_out_a: got token %0d, required none", dout_a);
                end else begin
                    e = q_a.pop_front();
                    chk("data_out_a", 32'(dout_a), 32'(e));
                    n_rx_a++;
                end
                held = dout_a;
            end else if (req_out_a) begin
                chk("data_out_a_stable", 32'(dout_a), 32'(held));
            end
            prev = req_out_a;
        end
    end

    // Responder A: 4-phase acknowledge after an optional random delay.
    initial begin
        int dly;
        int i;
        ack_out_a = 1'b0;
        forever begin
            @(negedge clk);
            if (req_out_a && !hold_a) begin
                dly = rnd_a ? int'($urandom_range(0, 5)) : 0;
                repeat (dly) @(negedge clk);
                ack_out_a = 1'b1;
                for (i = 0; i < 200 && req_out_a; i++) @(negedge clk);
                if (req_out_a) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL req_out_a_rtz: got 1, required 0");
                end
                ack_out_a = 1'b0;
            end
        end
    end

    // Monitor B: every req_out transition is a token; count ack_in transitions.
    initial begin
        logic pr;
        logic pa;
        logic [W-1:0] e;
        pr = 1'b0;
        pa = 1'b0;
        forever begin
            @(negedge clk);
            if (req_out_b != pr) begin
                n_reqt_b++;
                if (q_b.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stray_req_out_b: got token %0d, required none", dout_b);
                end else begin
                    e = q_b.pop_front();
                    chk("data_out_b", 32'(dout_b), 32'(e));
                    n_rx_b++;
                end
            end
            if (ack_in_b != pa) n_ackt_b++;
            pr = req_out_b;
            pa = ack_in_b;
        end
    end

    // Responder B: 2-phase, mirror req_out one clk later.
    initial begin
        ack_out_b = 1'b0;
        forever begin
            @(negedge clk);
            if (req_out_b != ack_out_b) begin
                @(negedge clk);
                ack_out_b = req_out_b;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [W-1:0] v;
        rst = 1'b1;
        req_a = 1'b0;
        din_a = '0;
        req_b = 1'b0;
        din_b = '0;
        #2;
        chk("rst_ack_in", 32'(ack_in_a), 0);
        chk("rst_req_out", 32'(req_out_a), 0);
        chk("rst_data_out", 32'(dout_a), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single token, latency check
        hold_a = 1'b0;
        @(posedge clk);
        #1;
        din_a = 3'b101;
        req_a = 1'b1;
        q_a.push_back(3'b101);
        @(posedge clk);
        @(negedge clk) chk("t1_ack_e0", 32'(ack_in_a), 0);
        @(posedge clk);
        @(negedge clk) chk("t1_ack_e1", 32'(ack_in_a), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_ack_e2", 32'(ack_in_a), 1);
        chk("t1_count_e2", 32'(cnt_a), 1);
        chk("t1_empty_e2", 32'(empty_a), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_data_e3", 32'(dout_a), 5);
        chk("t1_req_e3", 32'(req_out_a), 0);
        @(posedge clk);
        @(negedge clk) chk("t1_req_e4", 32'(req_out_a), 1);
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_ack_a(1'b0, "t1_ack_fall");
        drain_a("t1");

        // fill to DEPTH with the output stalled
        hold_a = 1'b1;
        for (int i = 1; i <= 4; i++) send_a(W'(i));
        repeat (4) @(negedge clk);
        chk("t2_full", 32'(full_a), 1);
        chk("t2_count", 32'(cnt_a), 4);
        @(posedge clk);
        #1;
        din_a = 3'd5;
        req_a = 1'b1;
        q_a.push_back(3'd5);
        repeat (12) @(negedge clk);
        chk("t2_ack_withheld", 32'(ack_in_a), 0);
        chk("t2_count_held", 32'(cnt_a), 4);
        hold_a = 1'b0;
        wait_ack_a(1'b1, "t2_fifth_acked");
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wait_ack_a(1'b0, "t2_fifth_fall");
        drain_a("t2");

        // streaming with random acknowledge delays
        rnd_a = 1'b1;
        k = n_rx_a;
        for (int i = 0; i < 100; i++) begin
            v = W'($urandom_range(0, 7));
            send_a(v);
        end
        drain_a("t3");
        chk("t3_received", n_rx_a - k, 100);
        rnd_a = 1'b0;

        // push and pop on the same edge at count = DEPTH-1
        hold_a = 1'b1;
        for (int i = 0; i < 3; i++) send_a(W'(i + 1));
        for (int i = 0; i < 50 && !req_out_a; i++) @(negedge clk);
        chk("t6_count_pre", 32'(cnt_a), 3);
        @(posedge clk);
        #1;
        hold_a = 1'b0;
        @(negedge clk);
        din_a = 3'd6;
        req_a = 1'b1;
        q_a.push_back(3'd6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_count_steady", 32'(cnt_a), 3);
            chk("t6_not_full", 32'(full_a), 0);
        end
        chk("t6_ack_in", 32'(ack_in_a), 1);
        req_a = 1'b0;
        wait_ack_a(1'b0, "t6_ack_fall");
        drain_a("t6");

        // reset in the middle of an output request
        hold_a = 1'b1;
        send_a(3'd2);
        send_a(3'd3);
        for (int i = 0; i < 50 && !req_out_a; i++) @(negedge clk);
        chk("t5_count_pre", 32'(cnt_a), 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_req_out_drop", 32'(req_out_a), 0);
        chk("t5_ack_in_drop", 32'(ack_in_a), 0);
        chk("t5_count_drop", 32'(cnt_a), 0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        hold_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_stale_req", 32'(req_out_a), 0);
        chk("t5_count_after", 32'(cnt_a), 0);

        // 2-phase instance: 8 transition tokens
        for (int i = 0; i < 8; i++) send_b(W'(i + 1));
        for (int i = 0; i < 300 && (cnt_b != 0 || n_rx_b < 8); i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("t4_ack_toggles", n_ackt_b, 8);
        chk("t4_req_toggles", n_reqt_b, 8);
        chk("t4_received", n_rx_b, 8);
        chk("t4_queue_left", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
